// File: rtl/polar_butterfly_stage_8.sv
// polar_butterfly_stage_8: serial polar-encoder butterfly stage of distance D=2**STAGE
// ports: clk; reset (async, active-high); enb (clock enable, freezes all state);
//        dataIn/validIn input bit stream; dataOut/validOut registered output bit stream
module polar_butterfly_stage_8 #(
  parameter int N     = 1024,
  parameter int STAGE = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic enb,
  input  logic dataIn,
  input  logic validIn,
  output logic dataOut,
  output logic validOut
);
  localparam int D = 2 ** STAGE;
  if (STAGE < 1 || N % (2 * D) != 0) begin : g_bad_params
    $error("polar_butterfly_stage_8: N must be a multiple of 2*2**STAGE and STAGE >= 1");
  end
  logic [D-1:0]     mem_q;
  logic [STAGE:0]   in_cnt_q, in_cnt_d;
  logic [STAGE-1:0] rd_ptr_q, rd_ptr_d, k;
  logic pend_q, pend_d, data_out_q, data_out_d, valid_out_q, valid_out_d;
  logic acc, ph, drain, last, out_v, out_bit;
  always_comb begin
    acc         = enb & validIn;
    ph          = in_cnt_q[STAGE];
    k           = in_cnt_q[STAGE-1:0];
    // a pending second-half bit leaves on any idle cycle, or alongside the first-half
    // accept that is about to overwrite its slot
    drain       = pend_q & (~acc | (~ph & (rd_ptr_q == k)));
    last        = acc & ph & (&k);
    out_v       = drain | (acc & ph);
    out_bit     = (acc & ph) ? mem_q[k] ^ dataIn : mem_q[rd_ptr_q];
    in_cnt_d    = acc ? in_cnt_q + 1'b1 : in_cnt_q;
    rd_ptr_d    = last ? '0 : drain ? rd_ptr_q + 1'b1 : rd_ptr_q;
    pend_d      = last | (pend_q & ~(drain & (&rd_ptr_q)));
    data_out_d  = out_v ? out_bit : data_out_q;
    valid_out_d = out_v;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_cnt_q    <= '0;
      rd_ptr_q    <= '0;
      pend_q      <= 1'b0;
      data_out_q  <= 1'b0;
      valid_out_q <= 1'b0;
    end else if (enb) begin
      in_cnt_q    <= in_cnt_d;
      rd_ptr_q    <= rd_ptr_d;
      pend_q      <= pend_d;
      data_out_q  <= data_out_d;
      valid_out_q <= valid_out_d;
    end
  end
  always_ff @(posedge clk) begin
    if (acc) mem_q[k] <= dataIn;
  end
  assign dataOut  = data_out_q;
  assign validOut = valid_out_q;
endmodule
